// File: rtl/vme_param_regbank.sv
// Parametrised VME control register bank: N_REGS R/W registers plus one read-only
// status word at address N_REGS, with optional input and output pipeline stages.
module vme_param_regbank #(
  parameter int                   N_REGS     = 4,
  parameter int                   REG_WIDTH  = 8,
  parameter int                   ADDR_WIDTH = 5,
  parameter logic [REG_WIDTH-1:0] RESET_VAL  = '0,
  parameter int                   PIPE_IN    = 1,
  parameter int                   PIPE_OUT   = 1
) (
  input  logic                          Clk,
  input  logic                          rst_n,
  input  logic [ADDR_WIDTH-1:0]         VMEAddr,
  input  logic [31:0]                   VMEWrData,
  input  logic                          VMERdMem,
  input  logic                          VMEWrMem,
  output logic [31:0]                   VMERdData,
  output logic                          VMERdDone,
  output logic                          VMEWrDone,
  output logic [N_REGS*REG_WIDTH-1:0]   regs_o,
  output logic [N_REGS-1:0]             wr_strobe_o,
  input  logic [31:0]                   sts_i
);

  // Handshake: VMERdMem/VMEWrMem are single-cycle request pulses with no backpressure;
  // every accepted request yields exactly one VMERdDone/VMEWrDone pulse, in order.

  logic                  wr_v;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [REG_WIDTH-1:0]  wr_data;

  // Upper write-data bits beyond REG_WIDTH are intentionally discarded.
  wire unused_wr_data = &{1'b0, VMEWrData};

  generate
    if (PIPE_IN != 0) begin : g_pipe_in
      logic                  v_q;
      logic [ADDR_WIDTH-1:0] a_q;
      logic [REG_WIDTH-1:0]  d_q;

      always_ff @(posedge Clk) begin
        if (!rst_n) begin
          v_q <= 1'b0;
          a_q <= '0;
          d_q <= '0;
        end else begin
          v_q <= VMEWrMem;
          a_q <= VMEAddr;
          d_q <= VMEWrData[REG_WIDTH-1:0];
        end
      end

      assign wr_v    = v_q;
      assign wr_addr = a_q;
      assign wr_data = d_q;
    end else begin : g_no_pipe_in
      assign wr_v    = VMEWrMem;
      assign wr_addr = VMEAddr;
      assign wr_data = VMEWrData[REG_WIDTH-1:0];
    end
  endgenerate

  // Status and unmapped addresses never match a select bit, so such writes only ack.
  logic [N_REGS-1:0] wr_sel;
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < N_REGS; i++) begin
      if (wr_v && (wr_addr == ADDR_WIDTH'(i))) wr_sel[i] = 1'b1;
    end
  end

  logic [REG_WIDTH-1:0] regs [N_REGS];
  logic [N_REGS-1:0]    wr_strobe_q;
  logic                 wr_done_q;

  always_ff @(posedge Clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REGS; i++) regs[i] <= RESET_VAL;
      wr_strobe_q <= '0;
      wr_done_q   <= 1'b0;
    end else begin
      for (int i = 0; i < N_REGS; i++) begin
        if (wr_sel[i]) regs[i] <= wr_data;
      end
      wr_strobe_q <= wr_sel;
      wr_done_q   <= wr_v;
    end
  end

  always_comb begin
    regs_o = '0;
    for (int i = 0; i < N_REGS; i++) regs_o[i*REG_WIDTH +: REG_WIDTH] = regs[i];
  end

  assign wr_strobe_o = wr_strobe_q;
  assign VMEWrDone   = wr_done_q;

  // Read decode sees the registers before any write landing this cycle.
  logic [31:0] rd_data_c;
  always_comb begin
    rd_data_c = '0;
    for (int i = 0; i < N_REGS; i++) begin
      if (VMEAddr == ADDR_WIDTH'(i)) rd_data_c = 32'(regs[i]);
    end
    if (VMEAddr == ADDR_WIDTH'(N_REGS)) rd_data_c = sts_i;
  end

  generate
    if (PIPE_OUT != 0) begin : g_pipe_out
      logic        rd_done_q;
      logic [31:0] rd_data_q;

      always_ff @(posedge Clk) begin
        if (!rst_n) begin
          rd_done_q <= 1'b0;
          rd_data_q <= '0;
        end else begin
          rd_done_q <= VMERdMem;
          if (VMERdMem) rd_data_q <= rd_data_c;
        end
      end

      assign VMERdDone = rd_done_q;
      assign VMERdData = rd_data_q;
    end else begin : g_no_pipe_out
      assign VMERdDone = VMERdMem & rst_n;
      assign VMERdData = (VMERdMem & rst_n) ? rd_data_c : '0;
    end
  endgenerate

endmodule

// File: doc/vme_param_regbank.md
# vme_param_regbank

Parametrised VME-side control register bank: N_REGS read/write registers of REG_WIDTH bits plus one read-only status word, decoded by word address from a single-cycle VME read/write strobe interface. It is the generalised successor of the single-register generated banks. Width, depth and the input/output pipeline stages are set by parameters, and it adds address decode, per-register write strobes and unmapped-address handling. It sits between the VME slave core and the user logic it configures.

## Interface
- N_REGS, 4: number of R/W registers, 1..16
- REG_WIDTH, 8: bits per register, 1..32
- ADDR_WIDTH, 5: word-address width; 2**ADDR_WIDTH must be > N_REGS
- RESET_VAL, 0: reset value of every R/W register (REG_WIDTH bits)
- PIPE_IN, 1: 0/1; registers write address, data and strobe before decode
- PIPE_OUT, 1: 0/1; registers read data and read done
- Clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- VMEAddr  in  ADDR_WIDTH  word address, valid with VMERdMem/VMEWrMem
- VMEWrData  in  32  write data
- VMERdMem  in  1  read request, one-cycle pulse
- VMEWrMem  in  1  write request, one-cycle pulse
- VMERdData  out  32  read data, valid when VMERdDone=1
- VMERdDone  out  1  read acknowledge, one-cycle pulse
- VMEWrDone  out  1  write acknowledge, one-cycle pulse
- regs_o  out  N_REGS*REG_WIDTH  register contents; register i at bits [i*REG_WIDTH +: REG_WIDTH]
- wr_strobe_o  out  N_REGS  one-cycle pulse on bit i when register i is written
- sts_i  in  32  read-only status word, sampled on read

## Operation
- Address map (word addresses): 0..N_REGS-1 are R/W registers. N_REGS is the status word (sts_i), which is read-only. All higher addresses are unmapped.
- Write to register i: register i is loaded with VMEWrData[REG_WIDTH-1:0]. Upper data bits are ignored.
- Write to the status word or to an unmapped address: no register changes, no strobe, VMEWrDone still pulses.
- Read of register i: returns the register zero-extended to 32 bits.
- Read of the status word: returns sts_i as sampled in the cycle VMERdMem=1.
- Read of an unmapped address: returns 0x00000000, with VMERdDone still pulsing.
- Read and write paths are independent. VMERdMem and VMEWrMem may be high in the same cycle, to the same or different addresses, and both complete.
- A read in the same cycle a write takes effect returns the pre-write value.
- Requests are single-cycle pulses, and back-to-back requests on consecutive cycles are legal. No request is ever dropped or merged outside reset.
- Reset (rst_n=0 at a clock edge) sets:
  - every register to RESET_VAL;
  - VMERdData to 0;
  - VMERdDone, VMEWrDone and wr_strobe_o to 0;
  - all pipeline stages to empty.
- Reset mid-operation: requests in flight are discarded, with no done and no register update. A request presented while rst_n=0 is ignored.

## Timing
- Request cycle T is the cycle in which VMEWrMem or VMERdMem is high.
- Write latency with PIPE_IN=1:
  - address, data and strobe are registered at the end of T;
  - decode happens in T+1;
  - the register update, regs_o change, wr_strobe_o pulse and VMEWrDone pulse all occur in T+2.
- Write latency with PIPE_IN=0: the same events occur in T+1.
- VMEWrDone and wr_strobe_o come from the same registered write-acknowledge. They are coincident with the new value on regs_o.
- Read with PIPE_OUT=1: decode is combinational in T, and VMERdDone and VMERdData are registered, valid in T+1.
- Read with PIPE_OUT=0: VMERdDone = VMERdMem combinationally. VMERdData is valid in T and is 0 whenever VMERdMem=0.
- With PIPE_OUT=1, VMERdData holds its last value between reads.
- Throughput: one read and one write per cycle, sustained.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with RESET_VAL=8'hA5. Required: regs_o = all registers 0xA5, all done and strobe outputs 0, VMERdData=0.
- Write/read-back: write 0x12345678 to address 2 (N_REGS=4, REG_WIDTH=8, PIPE_IN=1). Required: VMEWrDone and wr_strobe_o=4'b0100 in T+2, register 2 = 0x78. A later read of address 2 gives VMERdData=0x00000078 with VMERdDone in T+1.
- Status and unmapped: sts_i=0xCAFEF00D. Read address 4 returns 0xCAFEF00D. Read address 9 returns 0, with done pulsing. A write to address 9 pulses VMEWrDone only; regs_o and wr_strobe_o are unchanged.
- Simultaneous and back-to-back:
  - write 0x11 to address 1 while reading address 1 in the same cycle; the read returns the old value;
  - write 0x21, 0x22, 0x23 to addresses 0, 1, 2 on consecutive cycles; three VMEWrDone pulses on consecutive cycles, and the final registers are 0x21/0x22/0x23.
- Pipeline variants: repeat write/read-back with PIPE_IN=0 (WrDone in T+1) and PIPE_OUT=0 (RdDone and data in T, data 0 when idle).
- Reset mid-write: VMEWrMem in T, rst_n=0 in T+1. Required: no VMEWrDone, and the register stays at RESET_VAL.
